// File: rtl/fp_to_fixed.sv
// Two-stage IEEE-754 float to signed fixed-point converter with valid/ready on both sides.
// Stage 1 decodes and classifies the input; stage 2 shifts, rounds to nearest even, negates and saturates.
module fp_to_fixed #(
  parameter int W    = 32,
  parameter int IW   = 32,
  parameter int FRAC = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] y,
  output logic          overflow,
  output logic          inexact
);

  localparam int FW   = (W == 64) ? 52 : 23;
  localparam int EW   = (W == 64) ? 11 : 8;
  localparam int BIAS = (W == 64) ? 1023 : 127;
  localparam int SHW  = 16;
  localparam int K    = BIAS + FW - FRAC;
  // Left-shift result is wide enough to hold any in-range shift; right-shift keeps guard+sticky below the mantissa.
  localparam int MW   = FW + 1 + IW;
  localparam int RW   = 2 * FW + 3;

  localparam logic [SHW-1:0] SH_IW   = SHW'(IW);
  localparam logic [SHW-1:0] SH_RMAX = SHW'(FW + 1);
  localparam logic [MW-1:0]  LIM_POS = {{(MW-IW+1){1'b0}}, {(IW-1){1'b1}}};
  localparam logic [MW-1:0]  LIM_NEG = {{(MW-IW){1'b0}}, 1'b1, {(IW-1){1'b0}}};
  localparam logic [IW-1:0]  SAT_POS = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0]  SAT_NEG = {1'b1, {(IW-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_DENORM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  logic adv1;
  logic adv2;
  logic accept;

  logic                  sign_in;
  logic [EW-1:0]         exp_in;
  logic [FW-1:0]         frac_in;
  cls_t                  cls_in;
  logic signed [SHW-1:0] sh_in;

  logic                  s1_valid;
  logic                  s1_sign;
  cls_t                  s1_cls;
  logic [FW:0]           s1_man;
  logic signed [SHW-1:0] s1_sh;

  logic                  s2_valid;

  logic                  sh_neg;
  logic [SHW-1:0]        sh_mag;
  logic [MW-1:0]         lshift;
  logic [RW-1:0]         rext;
  logic [FW:0]           int_part;
  logic                  guard;
  logic                  sticky;
  logic                  rnd_inc;
  logic [MW-1:0]         mag_r;
  logic [MW-1:0]         mag;
  logic [MW-1:0]         lim;
  logic                  ovf;
  logic                  inx;
  logic [IW-1:0]         y_next;
  logic                  ovf_next;
  logic                  inx_next;

  // Handshake: a stage may load when it is empty or the stage after it is moving.
  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1 & ~reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  // Stage 1: field decode and classification.
  assign sign_in = a[W-1];
  assign exp_in  = a[W-2:FW];
  assign frac_in = a[FW-1:0];
  assign sh_in   = $signed(SHW'(exp_in)) - $signed(SHW'(K));

  always_comb begin
    cls_in = CLS_NORM;
    if (exp_in == '0) begin
      cls_in = (frac_in == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (exp_in == '1) begin
      cls_in = (frac_in == '0) ? CLS_INF : CLS_NAN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_sign <= sign_in;
      s1_cls  <= cls_in;
      s1_man  <= {1'b1, frac_in};
      s1_sh   <= sh_in;
    end
  end

  // Stage 2: shift, round, saturate, negate.
  always_comb begin
    sh_neg   = s1_sh[SHW-1];
    sh_mag   = sh_neg ? SHW'(-s1_sh) : SHW'(s1_sh);
    lshift   = MW'(s1_man) << sh_mag;
    rext     = {s1_man, {(FW+2){1'b0}}} >> sh_mag;
    int_part = rext[RW-1:FW+2];
    guard    = rext[FW+1];
    sticky   = |rext[FW:0];
    rnd_inc  = guard & (sticky | int_part[0]);
    mag_r    = MW'(int_part) + MW'(rnd_inc);
    lim      = s1_sign ? LIM_NEG : LIM_POS;
    mag      = '0;
    ovf      = 1'b0;
    inx      = 1'b0;
    y_next   = '0;
    ovf_next = 1'b0;
    inx_next = 1'b0;

    unique case (s1_cls)
      CLS_ZERO: begin
        y_next = '0;
      end
      CLS_DENORM: begin
        inx_next = 1'b1;
      end
      CLS_INF: begin
        ovf_next = 1'b1;
        y_next   = s1_sign ? SAT_NEG : SAT_POS;
      end
      CLS_NAN: begin
        ovf_next = 1'b1;
      end
      default: begin
        if (!sh_neg) begin
          if (sh_mag >= SH_IW) begin
            ovf = 1'b1;
          end else begin
            mag = lshift;
          end
        end else if (sh_mag > SH_RMAX) begin
          // Whole mantissa sits below the guard position: always rounds to 0.
          mag = '0;
          inx = 1'b1;
        end else begin
          mag = mag_r;
          inx = guard | sticky;
        end

        // Checked after rounding so a rounding carry can still saturate.
        if (ovf || (mag > lim)) begin
          ovf_next = 1'b1;
          inx_next = 1'b0;
          y_next   = s1_sign ? SAT_NEG : SAT_POS;
        end else begin
          inx_next = inx;
          y_next   = s1_sign ? (~mag[IW-1:0] + 1'b1) : mag[IW-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      y        <= '0;
      overflow <= 1'b0;
      inexact  <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y        <= y_next;
        overflow <= ovf_next;
        inexact  <= inx_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// Scoreboard bench for fp_to_fixed: directed float vectors with hand-computed results,
// driven under full throughput, backpressure, random handshake and mid-flight reset.
module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        overflow;
  logic        inexact;

  fp_to_fixed #(.W(32), .IW(32), .FRAC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  localparam int NV = 24;
  // {a, expected y, expected overflow, expected inexact}
  logic [65:0] vec [NV] = '{
    {32'h3F800000, 32'h00000010, 1'b0, 1'b0},  // 1.0
    {32'hC0200000, 32'hFFFFFFD8, 1'b0, 1'b0},  // -2.5
    {32'h3D000000, 32'h00000000, 1'b0, 1'b1},  // 2^-5 tie to even
    {32'h3DC00000, 32'h00000002, 1'b0, 1'b1},  // 3/32
    {32'h3D400000, 32'h00000001, 1'b0, 1'b1},  // 3/64
    {32'h4E800000, 32'h7FFFFFFF, 1'b1, 1'b0},  // 2^30
    {32'hCD000000, 32'h80000000, 1'b0, 1'b0},  // -2^27 exactly representable
    {32'h7FC00000, 32'h00000000, 1'b1, 1'b0},  // qNaN
    {32'hFF800000, 32'h80000000, 1'b1, 1'b0},  // -Inf
    {32'h00000000, 32'h00000000, 1'b0, 1'b0},  // +0
    {32'h80000000, 32'h00000000, 1'b0, 1'b0},  // -0
    {32'h00000001, 32'h00000000, 1'b0, 1'b1},  // denormal
    {32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},  // +Inf
    {32'h4D000000, 32'h7FFFFFFF, 1'b1, 1'b0},  // +2^27 just too big
    {32'h3F400000, 32'h0000000C, 1'b0, 1'b0},  // 0.75
    {32'h3CFFFFFF, 32'h00000000, 1'b0, 1'b1},  // below 2^-5: flush range
    {32'hBDC00000, 32'hFFFFFFFE, 1'b0, 1'b1},  // -3/32
    {32'h3DA00000, 32'h00000001, 1'b0, 1'b1},  // 1.25 lsb, round down
    {32'h3E200000, 32'h00000002, 1'b0, 1'b1},  // 2.5 lsb, tie to even down
    {32'h3E600000, 32'h00000004, 1'b0, 1'b1},  // 3.5 lsb, tie to even up
    {32'h4EFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0},  // large positive
    {32'h4CFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},  // 2^27-8, largest in range
    {32'h7F800001, 32'h00000000, 1'b1, 1'b0},  // sNaN
    {32'hCF000000, 32'h80000000, 1'b1, 1'b0}   // -2^31
  };

  logic [33:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        held_v   = 1'b0;
  logic [33:0] held;
  logic        done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every emit, and checks outputs hold while stalled.
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (out_valid && held_v) begin
        check("hold_out", {30'd0, y, overflow, inexact}, {30'd0, held});
      end
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(y), 64'hDEAD_BEEF_0000_0000);
        end else begin
          logic [33:0] e;
          e = sb.pop_front();
          check("out_y", 64'(y), 64'(e[33:2]));
          check("out_ovf", 64'(overflow), 64'(e[1]));
          check("out_inx", 64'(inexact), 64'(e[0]));
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {y, overflow, inexact};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // Presents one vector and returns one cycle after it was accepted.
  task automatic send(input int idx, output int stalls);
    bit ok;
    ok       = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    a        = vec[idx][65:34];
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(vec[idx][33:0]);
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int total_st;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    out_ready = 1'b1;
    done      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready_in_reset", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_flags", 64'({overflow, inexact}), 64'd0);

    // Latency: accepted in one cycle, out_valid two cycles later.
    send(0, st);
    check("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_2cyc", 64'(out_valid), 64'd1);
    drain();

    // Back-to-back stream: no bubbles with out_ready held high.
    total_st = 0;
    for (int i = 0; i < NV; i++) begin
      send(i, st);
      total_st += st;
    end
    check("throughput_stalls", 64'(total_st), 64'd0);
    drain();

    // Backpressure: two items fill the pipe, the rest wait for out_ready.
    out_ready = 1'b0;
    send(1, st);
    send(3, st);
    @(negedge clk);
    check("in_ready_full", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    fork
      begin
        send(6, st);
        send(8, st);
        send(21, st);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random handshake timing over the whole table.
    for (int pass = 0; pass < 3; pass++) begin
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < NV; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send(i, st);
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      out_ready = 1'b1;
      drain();
    end

    // Reset with two items in flight: both dropped.
    out_ready = 1'b0;
    send(5, st);
    send(6, st);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flush_valid", 64'(out_valid), 64'd0);
    check("rst_flush_y", 64'(y), 64'd0);
    check("rst_flush_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    send(0, st);
    drain();
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_no_extra", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
